ysyx_25020037_mem_arbiter: RTL and testbench

//   Two-master arbiter sharing the single core memory port between the icache refill port (read-only)
//   and the LSU (read/write). Sits between icache/LSU and the bus bridge; one transaction outstanding.

---
 rtl/ysyx_25020037_pkg.sv | 19 +
 rtl/ysyx_25020037_sat_counter.sv | 29 ++
 rtl/ysyx_25020037_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_ysyx_25020037_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020037_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding,
// master identifiers and the grant-selection rule.
package ysyx_25020037_pkg;

    // Arbiter FSM states; the encoding is fixed so external debug logic can decode it
    localparam logic [1:0] ARB_IDLE   = 2'b00;
    localparam logic [1:0] ARB_GNT_IC = 2'b01;
    localparam logic [1:0] ARB_GNT_LS = 2'b10;

    // Master identifiers
    localparam logic MASTER_IC = 1'b0;
    localparam logic MASTER_LS = 1'b1;

    // LSU wins by default; a starved icache request overrides it
    function automatic logic pick_ls(input logic ls_req, input logic ic_req, input logic ic_starved);
        return ls_req && !(ic_req && ic_starved);
    endfunction

endpackage

// File: rtl/ysyx_25020037_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
// at_limit is high while the count equals LIMIT; the count never wraps.
module ysyx_25020037_sat_counter #(
    parameter int LIMIT = 8,
    parameter int WIDTH = $clog2(LIMIT) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [WIDTH-1:0] count_reg;

    assign at_limit = (count_reg == WIDTH'(LIMIT));

    // Count up until LIMIT, hold there, return to zero on clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && !at_limit) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ysyx_25020037_mem_arbiter.sv
// Two-master arbiter in front of the core memory port: icache refill
// (read-only) and LSU (read/write), one transaction outstanding.
// LSU has default priority; a starvation counter forces an icache grant,
// and a watchdog raises a sticky flag on a hung transfer.
module ysyx_25020037_mem_arbiter
    import ysyx_25020037_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ic_req,
    input  logic [ADDR_WIDTH-1:0]   ic_addr,
    output logic                    ic_ready,
    output logic [DATA_WIDTH-1:0]   ic_rdata,
    input  logic                    ls_req,
    input  logic                    ls_wen,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_wmask,
    output logic                    ls_ready,
    output logic [DATA_WIDTH-1:0]   ls_rdata,
    output logic                    mem_req,
    output logic                    mem_wen,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready,
    output logic                    timeout
);

    logic [1:0]              state_reg;
    logic                    mem_req_reg;
    logic                    mem_wen_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;
    logic [DATA_WIDTH/8-1:0] mem_wmask_reg;
    logic                    timeout_reg;

    logic in_idle;
    logic in_gnt;
    logic in_gnt_ic;
    logic in_gnt_ls;
    logic starve_at_limit;
    logic wd_at_limit;
    logic grant_ls;
    logic grant_ic;

    assign in_idle   = (state_reg == ARB_IDLE);
    assign in_gnt_ic = (state_reg == ARB_GNT_IC);
    assign in_gnt_ls = (state_reg == ARB_GNT_LS);
    assign in_gnt    = in_gnt_ic || in_gnt_ls;

    // Requests are only looked at in IDLE
    assign grant_ls = in_idle && pick_ls(ls_req, ic_req, starve_at_limit);
    assign grant_ic = in_idle && !grant_ls && ic_req;

    // Cycles the icache request has waited; cleared when it wins or drops
    ysyx_25020037_sat_counter #(
        .LIMIT (STARVE_LIMIT),
        .WIDTH ($clog2(STARVE_LIMIT) + 1)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (ic_req && !in_gnt_ic),
        .clr      (!ic_req || grant_ic),
        .at_limit (starve_at_limit)
    );

    // Cycles spent in the current grant; at_limit marks the last allowed cycle
    ysyx_25020037_sat_counter #(
        .LIMIT (TIMEOUT - 1),
        .WIDTH ($clog2(TIMEOUT) + 1)
    ) u_wd_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (in_gnt && !mem_ready),
        .clr      (!in_gnt || mem_ready),
        .at_limit (wd_at_limit)
    );

    // Grant FSM: latch the winner's command in IDLE, hold it until mem_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ARB_IDLE;
            mem_req_reg   <= 1'b0;
            mem_wen_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wmask_reg <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (grant_ls) begin
                        state_reg     <= ARB_GNT_LS;
                        mem_req_reg   <= 1'b1;
                        mem_wen_reg   <= ls_wen;
                        mem_addr_reg  <= ls_addr;
                        mem_wdata_reg <= ls_wdata;
                        mem_wmask_reg <= ls_wen ? ls_wmask : '0;
                    end else if (grant_ic) begin
                        state_reg     <= ARB_GNT_IC;
                        mem_req_reg   <= 1'b1;
                        mem_wen_reg   <= 1'b0;
                        mem_addr_reg  <= ic_addr;
                        mem_wdata_reg <= '0;
                        mem_wmask_reg <= '0;
                    end
                end
                ARB_GNT_IC, ARB_GNT_LS: begin
                    if (mem_ready) begin
                        state_reg   <= ARB_IDLE;
                        mem_req_reg <= 1'b0;
                        mem_wen_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= ARB_IDLE;
                    mem_req_reg <= 1'b0;
                    mem_wen_reg <= 1'b0;
                end
            endcase
        end
    end

    // Sticky watchdog flag; the transfer itself keeps waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_reg <= 1'b0;
        end else if (in_gnt && wd_at_limit && !mem_ready) begin
            timeout_reg <= 1'b1;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_wen   = mem_wen_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wmask = mem_wmask_reg;
    assign timeout   = timeout_reg;

    // Completion and read data are routed only to the granted master
    assign ic_ready = in_gnt_ic && mem_ready;
    assign ls_ready = in_gnt_ls && mem_ready;
    assign ic_rdata = in_gnt_ic ? mem_rdata : '0;
    assign ls_rdata = in_gnt_ls ? mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_25020037_mem_arbiter.sv
// Self-checking bench for the memory arbiter: a per-cycle vector table for
// single transfers and arbitration, plus hand-written starvation, watchdog
// and mid-grant reset sequences.
module tb_ysyx_25020037_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic [31:0] ic_rdata;
    logic        ls_req;
    logic        ls_wen;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wmask;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    ysyx_25020037_mem_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (8),
        .TIMEOUT      (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_ready  (ic_ready),
        .ic_rdata  (ic_rdata),
        .ls_req    (ls_req),
        .ls_wen    (ls_wen),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_wmask  (ls_wmask),
        .ls_ready  (ls_ready),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "time limit");
    end

    typedef struct packed {
        logic        icr;
        logic [31:0] ica;
        logic        lsr;
        logic        lsw;
        logic [31:0] lsa;
        logic [31:0] lswd;
        logic [3:0]  lsm;
        logic [31:0] mrd;
        logic        mrdy;
        logic        e_mreq;
        logic        e_mwen;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic [3:0]  e_mwm;
        logic        e_icrdy;
        logic [31:0] e_icrd;
        logic        e_lsrdy;
        logic [31:0] e_lsrd;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ic_req = 1'b0; ic_addr = '0;
        ls_req = 1'b0; ls_wen = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        mem_rdata = '0; mem_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] a_ic;
        logic [31:0] a_ls;
        logic        grant_is_ic [6];
        logic        exp_order [6];
        int          ng;

        // icr, ica, lsr, lsw, lsa, lswd, lsm, mrd, mrdy | mreq, mwen, maddr, mwd, mwm, icrdy, icrd, lsrdy, lsrd
        // Icache read, ready on the third grant cycle
        vecs[0]  = '{1, 32'h8000_0000, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0,
                     0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0};
        vecs[1]  = '{1, 32'h8000_0000, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0,
                     1, 0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0};
        vecs[2]  = vecs[1];
        vecs[3]  = '{1, 32'h8000_0000, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0000_0413, 1,
                     1, 0, 32'h8000_0000, 32'h0, 4'h0, 1, 32'h0000_0413, 0, 32'h0};
        // Stray mem_ready in IDLE is ignored
        vecs[4]  = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0000_0055, 1,
                     0, 0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0};
        // LSU write; fields stay latched even if the inputs wander
        vecs[5]  = '{0, 32'h0, 1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0, 0,
                     0, 0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0};
        vecs[6]  = '{0, 32'h0, 1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0, 0,
                     1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 0, 32'h0};
        vecs[7]  = '{0, 32'h0, 1, 1, 32'h0, 32'h0, 4'hF, 32'h0, 0,
                     1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 0, 32'h0};
        vecs[8]  = '{0, 32'h0, 1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 1,
                     1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1, 32'h1234_5678};
        vecs[9]  = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0,
                     0, 0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 0, 32'h0};
        // Simultaneous requests: LSU read first, icache after one IDLE cycle
        vecs[10] = '{1, 32'h8000_0040, 1, 0, 32'h8000_2000, 32'h0, 4'h0, 32'h0, 0,
                     0, 0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 0, 32'h0};
        vecs[11] = '{1, 32'h8000_0040, 1, 0, 32'h8000_2000, 32'h0, 4'h0, 32'hAAAA_5555, 1,
                     1, 0, 32'h8000_2000, 32'h0, 4'h0, 0, 32'h0, 1, 32'hAAAA_5555};
        vecs[12] = '{1, 32'h8000_0040, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0,
                     0, 0, 32'h8000_2000, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0};
        vecs[13] = '{1, 32'h8000_0040, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0010_0093, 1,
                     1, 0, 32'h8000_0040, 32'h0, 4'h0, 1, 32'h0010_0093, 0, 32'h0};
        vecs[14] = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0,
                     0, 0, 32'h8000_0040, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0};

        // Reset state, checked while reset is still asserted
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        #1;
        chk("reset mem_req", {31'b0, mem_req}, 32'h0);
        chk("reset mem_wen", {31'b0, mem_wen}, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset mem_wmask", {28'b0, mem_wmask}, 32'h0);
        chk("reset timeout", {31'b0, timeout}, 32'h0);
        $display("reset: mem_req=%b timeout=%b", mem_req, timeout);
        rst = 1'b1;

        // Table-driven cycles: drive at negedge, check 1 time unit later
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            ic_req = vecs[i].icr;    ic_addr = vecs[i].ica;
            ls_req = vecs[i].lsr;    ls_wen = vecs[i].lsw;   ls_addr = vecs[i].lsa;
            ls_wdata = vecs[i].lswd; ls_wmask = vecs[i].lsm;
            mem_rdata = vecs[i].mrd; mem_ready = vecs[i].mrdy;
            #1;
            chk($sformatf("row%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_mreq});
            chk($sformatf("row%0d mem_wen", i), {31'b0, mem_wen}, {31'b0, vecs[i].e_mwen});
            chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
            chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].e_mwd);
            chk($sformatf("row%0d mem_wmask", i), {28'b0, mem_wmask}, {28'b0, vecs[i].e_mwm});
            chk($sformatf("row%0d ic_ready", i), {31'b0, ic_ready}, {31'b0, vecs[i].e_icrdy});
            chk($sformatf("row%0d ic_rdata", i), ic_rdata, vecs[i].e_icrd);
            chk($sformatf("row%0d ls_ready", i), {31'b0, ls_ready}, {31'b0, vecs[i].e_lsrdy});
            chk($sformatf("row%0d ls_rdata", i), ls_rdata, vecs[i].e_lsrd);
            chk($sformatf("row%0d timeout", i), {31'b0, timeout}, 32'h0);
            $display("row %0d: mem_req=%b wen=%b addr=%h ic_ready=%b ls_ready=%b",
                     i, mem_req, mem_wen, mem_addr, ic_ready, ls_ready);
        end

        // Starvation: both requests held, 1-cycle transfers. The icache wait
        // count reaches 8 after four LSU grants; icache then wins, and with
        // the count cleared the next contest goes back to the LSU.
        a_ic = 32'h8000_0100;
        a_ls = 32'h8000_3000;
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        drive_idle();
        ic_req = 1'b1; ic_addr = a_ic;
        ls_req = 1'b1; ls_addr = a_ls;
        ng = 0;
        for (int cyc = 0; cyc < 30 && ng < 6; cyc++) begin
            @(negedge clk);
            #1;
            mem_ready = mem_req;
            mem_rdata = 32'h100 + 32'(cyc);
            if (mem_req) begin
                grant_is_ic[ng] = (mem_addr == a_ic);
                #1;
                if (grant_is_ic[ng]) begin
                    chk($sformatf("starve grant%0d ic_ready", ng), {31'b0, ic_ready}, 32'h1);
                    chk($sformatf("starve grant%0d ic_rdata", ng), ic_rdata, 32'h100 + 32'(cyc));
                end else begin
                    chk($sformatf("starve grant%0d ls_ready", ng), {31'b0, ls_ready}, 32'h1);
                end
                $display("starve grant %0d -> %s", ng, grant_is_ic[ng] ? "icache" : "lsu");
                ng++;
            end
        end
        chk("starve grant count", 32'(ng), 32'd6);
        for (int g = 0; g < 6; g++) begin
            if (g < ng)
                chk($sformatf("starve order%0d is_ic", g), {31'b0, grant_is_ic[g]}, {31'b0, exp_order[g]});
        end
        @(negedge clk);
        drive_idle();

        // Watchdog: LSU read with mem_ready withheld. Grant cycle k holds a
        // count of k-1, so the flag rises at the end of cycle 256.
        @(negedge clk);
        ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 32'h8000_4000;
        for (int k = 1; k <= 257; k++) begin
            @(negedge clk);
            #1;
            if (k == 1)   chk("wd mem_req granted", {31'b0, mem_req}, 32'h1);
            if (k == 256) chk("wd timeout before limit", {31'b0, timeout}, 32'h0);
            if (k == 257) chk("wd timeout at limit", {31'b0, timeout}, 32'h1);
        end
        $display("watchdog: timeout=%b mem_req=%b", timeout, mem_req);
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("wd late ls_ready", {31'b0, ls_ready}, 32'h1);
        chk("wd late ls_rdata", ls_rdata, 32'hCAFE_F00D);
        @(negedge clk);
        drive_idle();
        #1;
        chk("wd mem_req dropped", {31'b0, mem_req}, 32'h0);
        chk("wd timeout sticky", {31'b0, timeout}, 32'h1);
        repeat (3) @(negedge clk);
        #1;
        chk("wd timeout still sticky", {31'b0, timeout}, 32'h1);

        // Reset in the middle of an LSU write grant
        @(negedge clk);
        ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 32'h8000_5000;
        ls_wdata = 32'h1122_3344; ls_wmask = 4'h3;
        @(negedge clk);
        #1;
        chk("rst pre mem_req", {31'b0, mem_req}, 32'h1);
        chk("rst pre mem_wmask", {28'b0, mem_wmask}, 32'h3);
        #1;
        rst = 1'b0;
        #1;
        chk("rst async mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst async mem_wen", {31'b0, mem_wen}, 32'h0);
        chk("rst async mem_addr", mem_addr, 32'h0);
        chk("rst async timeout", {31'b0, timeout}, 32'h0);
        mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        chk("rst idle ls_ready", {31'b0, ls_ready}, 32'h0);
        chk("rst idle ls_rdata", ls_rdata, 32'h0);
        $display("reset mid-grant: mem_req=%b timeout=%b", mem_req, timeout);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        ic_req = 1'b1; ic_addr = 32'h8000_0200;
        @(negedge clk);
        #1;
        chk("post-rst mem_req", {31'b0, mem_req}, 32'h1);
        chk("post-rst mem_addr", mem_addr, 32'h8000_0200);
        chk("post-rst mem_wen", {31'b0, mem_wen}, 32'h0);
        mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        #1;
        chk("post-rst ic_ready", {31'b0, ic_ready}, 32'h1);
        chk("post-rst ic_rdata", ic_rdata, 32'h0000_0013);
        chk("post-rst ls_ready", {31'b0, ls_ready}, 32'h0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("post-rst done mem_req", {31'b0, mem_req}, 32'h0);
        $display("post-reset icache fetch: addr=%h", mem_addr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
